// File: rtl/messbauer_sweep_controller_pkg.sv
// Shared types and sizing helpers for the Mossbauer velocity-sweep controller.
package messbauer_sweep_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_DIRECT  = 3'd2,
        ST_RETRACE = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_t;

    // Width of the shared period counter: must hold the longest of the ARM,
    // channel and retrace intervals.
    function automatic int unsigned ctr_width(input int unsigned arm_len,
                                              input int unsigned period_len,
                                              input int unsigned retrace_len);
        int unsigned m;
        m = arm_len;
        if (period_len > m) m = period_len;
        if (retrace_len > m) m = retrace_len;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/messbauer_sweep_controller_period_counter.sv
// Modulo counter with run-time terminal count; wraps to 0 after reaching tc.
module messbauer_period_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    assign wrap = en && !clr && (count == tc);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/messbauer_sweep_controller.sv
// Sequences Mossbauer velocity sweeps: ARM hold, direct slope with per-channel
// strobes, retrace, and sweep counting with optional stop-after-N.
module messbauer_sweep_controller
    import messbauer_sweep_controller_pkg::*;
#(
    parameter int unsigned CHANNEL_NUMBER   = 512,
    parameter int unsigned CHANNEL_PERIOD   = 16,
    parameter int unsigned RETRACE_CHANNELS = 32,
    parameter int unsigned ARM_CYCLES       = 2,
    parameter int unsigned CH_WIDTH         = 9,
    parameter int unsigned SWEEP_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [SWEEP_WIDTH-1:0] cfg_sweeps,
    output logic                   gen_hold,
    output logic                   sweep_start,
    output logic                   channel_strobe,
    output logic [CH_WIDTH-1:0]    channel_index,
    output logic                   retrace,
    output logic                   busy,
    output logic [SWEEP_WIDTH-1:0] sweep_count,
    output logic                   done
);

    localparam int unsigned CW = ctr_width(ARM_CYCLES, CHANNEL_PERIOD,
                                           RETRACE_CHANNELS * CHANNEL_PERIOD);
    localparam logic [CW-1:0] TC_ARM   = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] TC_DIR   = CW'(CHANNEL_PERIOD - 1);
    localparam logic [CW-1:0] TC_RET   = CW'(RETRACE_CHANNELS * CHANNEL_PERIOD - 1);
    localparam logic [CW-1:0] PRE_WRAP = CW'(CHANNEL_PERIOD - 2);
    localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(CHANNEL_NUMBER - 1);

    sweep_state_t           state, state_n;
    logic [SWEEP_WIDTH-1:0] target, target_n, count_n, count_inc;
    logic [CH_WIDTH-1:0]    idx_n;
    logic [CW-1:0]          cnt, tc;
    logic                   cnt_en, cnt_clr, cnt_wrap;
    logic                   hold_n, sstart_n, strobe_n, retrace_n, busy_n, done_n;

    assign count_inc = sweep_count + 1'b1;
    assign cnt_en    = (state == ST_ARM) || (state == ST_DIRECT) || (state == ST_RETRACE);
    assign cnt_clr   = (state == ST_IDLE) || stop;

    always_comb begin
        tc = TC_DIR;
        case (state)
            ST_ARM:     tc = TC_ARM;
            ST_RETRACE: tc = TC_RET;
            default:    tc = TC_DIR;
        endcase
    end

    messbauer_period_counter #(
        .WIDTH (CW)
    ) u_period (
        .clk    (clk),
        .areset (areset),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .tc     (tc),
        .count  (cnt),
        .wrap   (cnt_wrap)
    );

    always_comb begin
        state_n  = state;
        target_n = target;
        count_n  = sweep_count;
        idx_n    = channel_index;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_n  = ST_ARM;
                    target_n = cfg_sweeps;
                    count_n  = '0;
                    idx_n    = '0;
                end
            end
            ST_ARM: begin
                if (stop) state_n = ST_IDLE;
                else if (cnt_wrap) state_n = ST_DIRECT;
            end
            ST_DIRECT: begin
                if (stop) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                end else if (cnt_wrap) begin
                    if (channel_index == LAST_CH) begin
                        state_n = ST_RETRACE;
                        idx_n   = '0;
                    end else begin
                        idx_n = channel_index + 1'b1;
                    end
                end
            end
            ST_RETRACE: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (cnt_wrap) begin
                    count_n = count_inc;
                    if ((target != '0) && (count_inc == target)) state_n = ST_DONE;
                    else state_n = ST_DIRECT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state; the
        // strobe looks one count ahead so it lands on the channel's last cycle.
        hold_n    = (state_n == ST_IDLE) || (state_n == ST_ARM) || (state_n == ST_DONE);
        sstart_n  = (state_n == ST_DIRECT) && (state != ST_DIRECT);
        strobe_n  = (state == ST_DIRECT) && !stop && (cnt == PRE_WRAP);
        retrace_n = (state_n == ST_RETRACE);
        busy_n    = (state_n != ST_IDLE);
        done_n    = (state_n == ST_DONE);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state          <= ST_IDLE;
            target         <= '0;
            sweep_count    <= '0;
            channel_index  <= '0;
            gen_hold       <= 1'b1;
            sweep_start    <= 1'b0;
            channel_strobe <= 1'b0;
            retrace        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            target         <= target_n;
            sweep_count    <= count_n;
            channel_index  <= idx_n;
            gen_hold       <= hold_n;
            sweep_start    <= sstart_n;
            channel_strobe <= strobe_n;
            retrace        <= retrace_n;
            busy           <= busy_n;
            done           <= done_n;
        end
    end

endmodule
